instr_fetch_queue: RTL and testbench

Parametrised prefetching instruction fetch unit, the next generation of the MVP fetch stage. It owns the PC, issues fetch requests to a variable-latency instruction memory over a request/grant/response interface, and buffers returned instructions with their PCs in a DEPTH-entry queue. The queue drains to decode over a valid/ready handshake. A redirect (branch/jump) flushes the queue and discards responses still in flight.

---
 rtl/instr_fetch_queue.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: prefetching instruction fetch unit.
//
// Owns the fetch PC and issues requests to a variable-latency instruction memory
// over req/gnt/rvalid. Returned words are tagged with their PC and buffered in a
// DEPTH-entry circular queue that drains to decode over valid/ready. A redirect
// flushes the queue and turns every outstanding request into a response to drop.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   redirect_en/addr  flush and restart fetch at redirect_addr
//   mem_req/addr/gnt  fetch request channel (accepted when mem_req & mem_gnt)
//   mem_rvalid/rdata  in-order fetch responses
//   out_valid/ready   head-of-queue handshake to decode
//   out_pc/out_instr  head entry (don't-care when out_valid = 0)
//   level             queue occupancy
module instr_fetch_queue #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PC_STEP     = 1,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect_en,
  input  logic [PC_WIDTH-1:0]          redirect_addr,
  output logic                         mem_req,
  output logic [PC_WIDTH-1:0]          mem_addr,
  input  logic                         mem_gnt,
  input  logic                         mem_rvalid,
  input  logic [INSTR_WIDTH-1:0]       mem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [INSTR_WIDTH-1:0]       out_instr,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0]         DepthC = (CW + 1)'(DEPTH);
  localparam logic [PC_WIDTH-1:0] StepC  = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       live_cnt_q, live_cnt_d;
  logic [CW-1:0]       drop_cnt_q, drop_cnt_d;

  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

  logic [CW:0]   in_use;
  logic          grant;
  logic          pop;
  logic          push;
  logic          drop_resp;
  logic [CW-1:0] rvalid_ext;
  logic [CW-1:0] push_ext;
  logic [CW-1:0] pop_ext;
  logic [CW-1:0] grant_ext;

  // Credit covers both queued entries and live requests, so every live response
  // is guaranteed a slot and a push is never refused. Dropped responses need none.
  assign in_use = {1'b0, count_q} + {1'b0, live_cnt_q};

  assign mem_req   = ~reset & ~redirect_en & (in_use < DepthC);
  assign mem_addr  = fetch_pc_q;
  assign out_valid = (count_q != '0) & ~redirect_en;
  assign out_pc    = pc_mem[rd_ptr_q];
  assign out_instr = instr_mem[rd_ptr_q];
  assign level     = count_q;

  assign grant     = mem_req & mem_gnt;
  assign pop       = out_valid & out_ready;
  assign push      = mem_rvalid & ~redirect_en & (drop_cnt_q == '0);
  assign drop_resp = mem_rvalid & ~redirect_en & (drop_cnt_q != '0);

  assign rvalid_ext = {{(CW-1){1'b0}}, mem_rvalid};
  assign push_ext   = {{(CW-1){1'b0}}, push};
  assign pop_ext    = {{(CW-1){1'b0}}, pop};
  assign grant_ext  = {{(CW-1){1'b0}}, grant};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    live_cnt_d = live_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (redirect_en) begin
      fetch_pc_d = redirect_addr;
      resp_pc_d  = redirect_addr;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      live_cnt_d = '0;
      // A response arriving now is from the old stream and is consumed here.
      drop_cnt_d = drop_cnt_q + live_cnt_q - rvalid_ext;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + StepC;
      end
      if (push) begin
        wr_ptr_d  = wr_ptr_q + 1'b1;
        resp_pc_d = resp_pc_q + StepC;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (drop_resp) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
      count_d    = count_q + push_ext - pop_ext;
      live_cnt_d = live_cnt_q + grant_ext - push_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      live_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      live_cnt_q <= live_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      instr_mem[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a behavioural memory (in-order, bounded latency,
// at most DEPTH outstanding) plus a reference model that tracks the decode-visible
// stream as a queue of PCs, with responses tagged by the stream they belong to.
module tb_instr_fetch_queue;

  localparam int unsigned PW    = 8;
  localparam int unsigned IW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam logic [PW-1:0] RPC = 8'h10;

  logic          clk;
  logic          reset;
  logic          redirect_en;
  logic [PW-1:0] redirect_addr;
  logic          mem_req;
  logic [PW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [IW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_pc;
  logic [IW-1:0] out_instr;
  logic [2:0]    level;

  instr_fetch_queue #(
    .PC_WIDTH   (PW),
    .INSTR_WIDTH(IW),
    .DEPTH      (DEPTH),
    .PC_STEP    (1),
    .RESET_PC   (RPC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .redirect_en  (redirect_en),
    .redirect_addr(redirect_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] addr;
    int            due;
    int            tag;
  } req_t;

  req_t          pend[$];   // requests granted and not yet answered
  logic [PW-1:0] q_pc[$];   // model of decode-visible queue
  logic [PW-1:0] seen_pc[$];
  logic [PW-1:0] fetch_pc;
  int            epoch;
  int            cyc;
  int            lat_min, lat_max;
  bit            gnt_allow;
  int            gnt_cnt, first_gnt, first_valid;
  int            vectors, miscompares;

  function automatic logic [IW-1:0] instr_of(input logic [PW-1:0] a);
    return {a ^ 8'hA5, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory, compare DUT against model mid-cycle, advance model.
  task automatic tick();
    int   live;
    bit   rv;
    bit   exp_req, exp_valid;
    req_t head;
    live = 0;
    foreach (pend[i]) if (pend[i].tag == epoch) live++;
    rv = !reset && (pend.size() != 0) && (pend[0].due <= cyc);
    if (rv) head = pend[0];
    mem_rvalid = rv;
    mem_rdata  = rv ? instr_of(head.addr) : IW'($urandom);
    mem_gnt    = gnt_allow && (pend.size() < DEPTH);
    exp_req    = !reset && !redirect_en && ((q_pc.size() + live) < DEPTH);
    exp_valid  = (q_pc.size() != 0) && !redirect_en;
    #4;
    check("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) check("mem_addr", 32'(mem_addr), 32'(fetch_pc));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("out_pc", 32'(out_pc), 32'(q_pc[0]));
      check("out_instr", 32'(out_instr), 32'(instr_of(q_pc[0])));
    end
    check("level", 32'(level), 32'(q_pc.size()));
    if (exp_req && mem_gnt) begin
      gnt_cnt++;
      if (first_gnt < 0) first_gnt = cyc;
    end
    if (exp_valid && out_ready) begin
      seen_pc.push_back(q_pc[0]);
      if (first_valid < 0) first_valid = cyc;
    end
    @(posedge clk);
    if (reset) begin
      q_pc.delete();
      pend.delete();
      epoch++;
      fetch_pc = RPC;
    end else if (redirect_en) begin
      q_pc.delete();
      if (rv) void'(pend.pop_front());
      epoch++;
      fetch_pc = redirect_addr;
    end else begin
      if (exp_valid && out_ready) void'(q_pc.pop_front());
      if (rv) begin
        void'(pend.pop_front());
        if (head.tag == epoch) q_pc.push_back(head.addr);
      end
      if (exp_req && mem_gnt) begin
        pend.push_back('{addr: fetch_pc,
                         due: cyc + int'($urandom_range(lat_max, lat_min)), tag: epoch});
        fetch_pc = fetch_pc + 8'd1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; epoch = 0;
    lat_min = 1; lat_max = 1; gnt_allow = 1'b1;
    gnt_cnt = 0; first_gnt = -1; first_valid = -1;
    fetch_pc = RPC;
    reset = 1'b1; redirect_en = 1'b0; redirect_addr = '0; out_ready = 1'b1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    // Bring DUT out of X before the model starts comparing.
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then streaming with 1-cycle memory.
    do_reset();
    first_gnt = -1; first_valid = -1; seen_pc.delete();
    run(10);
    check("first_valid_latency", 32'(first_valid - first_gnt), 32'd2);
    check("stream_pc0", 32'(seen_pc[0]), 32'h10);
    check("stream_pc1", 32'(seen_pc[1]), 32'h11);

    // Stalled consumer: credit stops fetching at DEPTH.
    do_reset();
    out_ready = 1'b0; gnt_cnt = 0;
    run(12);
    check("fill_grants", 32'(gnt_cnt), 32'd4);
    check("fill_level", 32'(level), 32'd4);
    out_ready = 1'b1; seen_pc.delete();
    run(8);
    for (int i = 0; i < 4; i++) check("drain_order", 32'(seen_pc[i]), 32'h10 + 32'(i));
    check("fetch_resume", 32'(seen_pc[4]), 32'h14);

    // Latency 3, two outstanding, redirect to 0x80.
    do_reset();
    lat_min = 3; lat_max = 3;
    run(2);
    gnt_allow = 1'b0;
    run(1);
    redirect_en = 1'b1; redirect_addr = 8'h80;
    tick();
    redirect_en = 1'b0;
    check("redir_level", 32'(level), 32'd0);
    check("redir_addr", 32'(mem_addr), 32'h80);
    gnt_allow = 1'b1; seen_pc.delete();
    run(12);
    check("redir_first_pc", 32'(seen_pc[0]), 32'h80);

    // Redirect in a cycle with a response and a ready consumer.
    lat_min = 1; lat_max = 1;
    run(6);
    redirect_en = 1'b1; redirect_addr = 8'h40;
    tick();
    redirect_en = 1'b0; seen_pc.delete();
    run(8);
    check("redir_rvalid_pc", 32'(seen_pc[0]), 32'h40);

    // Back-to-back redirects, then PC wrap.
    redirect_en = 1'b1; redirect_addr = 8'h33;
    tick();
    redirect_addr = 8'hFE;
    tick();
    redirect_en = 1'b0; seen_pc.delete();
    run(10);
    check("wrap_0", 32'(seen_pc[0]), 32'hFE);
    check("wrap_1", 32'(seen_pc[1]), 32'hFF);
    check("wrap_2", 32'(seen_pc[2]), 32'h00);
    check("wrap_3", 32'(seen_pc[3]), 32'h01);

    // Reset with a filled queue and a request in flight.
    lat_min = 2; lat_max = 2; out_ready = 1'b0;
    run(6);
    do_reset();
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fetch_pc", 32'(mem_addr), 32'(RPC));
    out_ready = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset       = ($urandom_range(99) == 0);
      redirect_en = ($urandom_range(14) == 0);
      redirect_addr = PW'($urandom);
      out_ready   = ($urandom_range(9) < 7);
      gnt_allow   = ($urandom_range(9) < 7);
      lat_min     = 1;
      lat_max     = int'($urandom_range(4, 1));
      tick();
    end
    reset = 1'b0; redirect_en = 1'b0; out_ready = 1'b1; gnt_allow = 1'b1;
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
